// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid handshake,
// holds the instruction for decode and advances the PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        pc,
    input  logic               retire,
    input  logic [2:0]         npc_op,
    input  logic signed [31:0] imm,
    input  logic [31:0]        alu_result,
    output logic [31:0]        instret,
    output logic               fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JALR   = 3'b100;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic        fault_q, fault_d;
    logic [31:0] next_pc;

    // Unknown opcodes fall through to sequential flow.
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (npc_op)
            OP_PLUS4:  next_pc = pc_q + 32'd4;
            OP_BRANCH: next_pc = pc_q + $unsigned(imm);
            OP_JUMP:   next_pc = pc_q + $unsigned(imm);
            OP_JALR:   next_pc = alu_result & ~32'h1;
            default:   next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        inst_d  = imem_rdata;
                        state_d = S_VALID;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (retire) begin
                    pc_d      = next_pc;
                    instret_d = instret_q + 32'd1;
                    // A misaligned target still retires, then parks the stage.
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            instret_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    // Request is gated by reset so nothing is issued while rstn is held low.
    assign imem_req    = rstn && (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == S_VALID);
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign instret     = instret_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus a randomized
// memory/retire phase checked against a PC/instret reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        retire;
    logic [2:0]  npc_op;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic [31:0] instret;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .pc          (pc),
        .retire      (retire),
        .npc_op      (npc_op),
        .imm         (imm),
        .alu_result  (alu_result),
        .instret     (instret),
        .fetch_fault (fetch_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] instret;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   presented = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_halt;
    logic        mem_auto = 1'b0;
    logic        ret_auto = 1'b0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [2:0] op,
                                             input logic [31:0] im, input logic [31:0] alu);
        if (op == 3'b001 || op == 3'b010) return p + im;
        if (op == 3'b100) return {alu[31:1], 1'b0};
        return p + 32'd4;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_pc      = 32'd0;
        m_instret = 32'd0;
        m_halt    = 1'b0;
        exp_q.push_back('{32'd0, memw(32'd0), 32'd0});
    endfunction

    function automatic void model_retire(input logic [2:0] op, input logic [31:0] im,
                                         input logic [31:0] alu);
        m_pc      = ref_next(m_pc, op, im, alu);
        m_instret = m_instret + 32'd1;
        if (m_pc[1:0] != 2'b00) m_halt = 1'b1;
        else exp_q.push_back('{m_pc, memw(m_pc), m_instret});
    endfunction

    // Monitor: every fresh presentation to decode is matched against the queue.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            prev_valid = 1'b0;
        end else begin
            if (inst_valid && !prev_valid) begin
                presented++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_inst", inst, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", pc, e.pc);
                    chk("mon_inst", inst, e.inst);
                    chk("mon_instret", instret, e.instret);
                end
            end
            prev_valid = inst_valid;
        end
    end

    // Randomized memory responder with grant wait, read latency and stray rvalids.
    initial begin
        logic        pend = 1'b0;
        logic [31:0] pend_addr = 32'd0;
        int          rv_cnt = 0;
        int          g_cnt = 0;
        int          lat;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pend  = 1'b0;
                g_cnt = 0;
            end else if (mem_auto) begin
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                if (pend) begin
                    if (rv_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memw(pend_addr);
                        pend        = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end else if (imem_req) begin
                    chk("req_addr", imem_addr, m_pc);
                    if (g_cnt == 0) begin
                        imem_gnt = 1'b1;
                        lat = $urandom_range(0, 3);
                        if (lat == 0) begin
                            imem_rvalid = 1'b1;
                            imem_rdata  = memw(imem_addr);
                        end else begin
                            pend      = 1'b1;
                            pend_addr = imem_addr;
                            rv_cnt    = lat - 1;
                        end
                        g_cnt = $urandom_range(0, 3);
                    end else begin
                        g_cnt--;
                        if ($urandom_range(0, 3) == 0) begin
                            imem_rvalid = 1'b1;
                            imem_rdata  = $urandom;
                        end
                    end
                end else if (inst_valid && $urandom_range(0, 3) == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = $urandom;
                end
            end
        end
    end

    // Randomized retire driver; keeps targets aligned (bit 0 of alu is masked by the DUT).
    initial begin
        logic [31:0] r;
        logic [2:0]  op;
        forever begin
            @(negedge clk);
            if (ret_auto) begin
                retire = 1'b0;
                if (rstn && inst_valid && !m_halt && $urandom_range(0, 2) == 0) begin
                    op         = 3'($urandom_range(0, 7));
                    imm        = 32'($urandom_range(0, 255)) * 32'd4 - 32'd512;
                    r          = $urandom;
                    alu_result = r & 32'hFFFF_FFFD;
                    npc_op     = op;
                    retire     = 1'b1;
                    model_retire(op, imm, alu_result);
                end
            end
        end
    end

    task automatic fetch_zero();
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = memw(m_pc);
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("fetch_valid", 32'(inst_valid), 32'd1);
        chk("fetch_inst", inst, memw(m_pc));
    endtask

    task automatic do_retire(input logic [2:0] op, input logic [31:0] im, input logic [31:0] alu);
        retire     = 1'b1;
        npc_op     = op;
        imm        = im;
        alu_result = alu;
        model_retire(op, im, alu);
        @(negedge clk);
        retire = 1'b0;
        chk("ret_pc", pc, m_pc);
        chk("ret_instret", instret, m_instret);
        chk("ret_req", 32'(imem_req), m_halt ? 32'd0 : 32'd1);
        chk("ret_fault", 32'(fetch_fault), 32'(m_halt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    endtask

    initial begin
        int base;
        rstn        = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        retire      = 1'b0;
        npc_op      = 3'd0;
        imm         = 32'd0;
        alu_result  = 32'd0;
        m_pc        = 32'd0;
        m_instret   = 32'd0;
        m_halt      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        model_reset();
        rstn = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        chk("first_valid", 32'(inst_valid), 32'd0);

        // Zero-latency fetch and sequential retire.
        fetch_zero();
        chk("zl_pc", pc, 32'd0);
        do_retire(3'b000, 32'd0, 32'd0);
        chk("plus4_pc", pc, 32'd4);

        // Grant held off three cycles, data two cycles after grant.
        repeat (3) begin
            chk("hold_req", 32'(imem_req), 32'd1);
            chk("hold_addr", imem_addr, 32'd4);
            @(negedge clk);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("wait_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("wait_valid", 32'(inst_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = memw(32'd4);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("late_valid", 32'(inst_valid), 32'd1);

        // Branch, jump and jalr targets.
        do_retire(3'b010, 32'h0000_00FC, 32'd0);
        fetch_zero();
        do_retire(3'b001, 32'hFFFF_FFF8, 32'd0);
        chk("branch_pc", pc, 32'h0000_00F8);
        fetch_zero();
        do_retire(3'b010, 32'h0000_0020, 32'd0);
        chk("jump_pc", pc, 32'h0000_0118);
        fetch_zero();
        do_retire(3'b100, 32'd0, 32'h0000_0205);
        chk("jalr_pc", pc, 32'h0000_0204);
        fetch_zero();
        do_retire(3'b011, 32'h0000_1000, 32'd0);
        chk("op011_pc", pc, 32'h0000_0208);

        // Retire outside VALID has no effect.
        retire = 1'b1;
        npc_op = 3'b010;
        imm    = 32'h0000_0040;
        @(negedge clk);
        chk("ret_in_req_pc", pc, 32'h0000_0208);
        chk("ret_in_req_cnt", instret, m_instret);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        @(negedge clk);
        chk("ret_in_wait_pc", pc, 32'h0000_0208);
        chk("ret_in_wait_cnt", instret, m_instret);
        retire      = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = memw(32'h0000_0208);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("after_wait_valid", 32'(inst_valid), 32'd1);

        // Randomized phase.
        base     = presented;
        mem_auto = 1'b1;
        ret_auto = 1'b1;
        repeat (4000) @(negedge clk);
        ret_auto = 1'b0;
        mem_auto = 1'b0;
        @(negedge clk);
        retire      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("rand_progress", 32'(presented - base >= 200), 32'd1);

        // Reset during WAIT, then a stale rvalid in REQ.
        rstn = 1'b0;
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        @(negedge clk);
        chk("re_req", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("re_wait_req", 32'(imem_req), 32'd0);
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        model_reset();
        rstn        = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("stale_valid", 32'(inst_valid), 32'd0);
        chk("stale_req", 32'(imem_req), 32'd1);
        chk("stale_addr", imem_addr, 32'd0);
        fetch_zero();

        // Misaligned jalr target halts the stage after counting the retire.
        do_retire(3'b100, 32'd0, 32'h0000_0206);
        chk("fault_pc", pc, 32'h0000_0206);
        chk("fault_cnt", instret, 32'd1);
        repeat (3) begin
            retire      = 1'b1;
            npc_op      = 3'b000;
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h1234_5678;
            @(negedge clk);
            chk("halt_pc", pc, 32'h0000_0206);
            chk("halt_cnt", instret, 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(inst_valid), 32'd0);
            chk("halt_fault", 32'(fetch_fault), 32'd1);
        end
        retire      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and requests instructions from instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction (opcode/funct fields) to decode.
- On retire, applies the decoder's NPCOp to form the next PC. Also counts retired instructions and traps misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (equals pc)
- imem_gnt  in  1  memory accepts request
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst holds a valid instruction for decode
- inst  out  32  registered instruction word
- pc  out  32  PC of the current instruction
- retire  in  1  current instruction completes this cycle
- npc_op  in  3  000 PLUS4, 001 BRANCH (taken), 010 JUMP, 100 JALR
- imm  in  32  sign-extended immediate from the extender
- alu_result  in  32  jalr target from the ALU
- instret  out  32  retired-instruction counter
- fetch_fault  out  1  sticky: misaligned next PC detected

Behaviour:
- Reset (rstn=0, async):
  - State REQ; pc=RESET_PC.
  - inst=0, inst_valid=0, instret=0, fetch_fault=0.
  - imem_req=0 while rstn is low.
- Output decoding:
  - imem_req=1 only in state REQ.
  - imem_addr=pc always.
  - inst_valid=1 only in state VALID.
- States and transitions:
  - REQ: imem_req=1; addr stays stable until gnt.
    - gnt=0 → stay in REQ.
    - gnt=1 and rvalid=0 → WAIT.
    - gnt=1 and rvalid=1 in the same cycle → capture inst=imem_rdata, go to VALID (zero-latency memory).
  - WAIT: rvalid=1 → capture inst, go to VALID; otherwise stay.
  - VALID: inst stable.
    - retire=1 → pc<=next_pc, instret<=instret+1, go to REQ (or HALT on fault).
  - HALT: inst_valid=0, imem_req=0.
    - Leaves only via reset.
    - retire, gnt and rvalid are ignored.
- next_pc (combinational, 32-bit, wraps modulo 2^32):
  - 000 → pc+4
  - 001 → pc+imm
  - 010 → pc+imm
  - 100 → alu_result & ~32'h1
  - Any other code → pc+4
- Misalignment: if next_pc[1:0]≠0 at retire:
  - Retire still counts (instret+1) and pc loads next_pc.
  - fetch_fault<=1; state → HALT.
- Ignored inputs:
  - rvalid outside WAIT, or outside REQ with gnt, is ignored.
  - retire outside VALID is ignored; no count, no PC change.
- Timing:
  - Minimum one instruction per 2 cycles with zero-latency memory (VALID→REQ→VALID).
  - Fetch latency from REQ = grant wait + read latency + 1 registered cycle.
- instret wraps 32'hFFFF_FFFF → 0.
- Reset mid-fetch (in WAIT or REQ) aborts the fetch.
  - After release, a fresh request is issued at RESET_PC.
  - A late rvalid for the aborted fetch arriving in REQ is ignored.

Test Plan:
- Reset then zero-latency memory (gnt=rvalid=1 same cycle), rdata=32'h00500093 → cycle after REQ: inst_valid=1, inst=32'h00500093, pc=0; retire with npc_op=000 → pc=4, instret=1.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt → imem_req held with addr stable for 3 cycles; inst_valid rises exactly 1 cycle after rvalid.
- At pc=0x100: branch npc_op=001 with imm=-8 → pc=0xF8. Jump npc_op=010 with imm=0x20 → pc=0x118. JALR npc_op=100 with alu_result=0x205 → pc=0x204.
- JALR with alu_result=0x206 → fetch_fault=1, state HALT, imem_req=0; subsequent retire/gnt have no effect; instret incremented once.
- Assert rstn=0 during WAIT, release, then drive a stale rvalid in REQ → ignored; new request issued at RESET_PC; outputs at reset values.
- retire pulsed during REQ/WAIT, and npc_op=011 in VALID → no PC change outside VALID; 011 yields pc+4.
